// File: rtl/ppu_sched.sv
// ppu_sched - sequencer for the pixel processing unit (PPU) in the VGA pipeline.
//
// Purpose:
//   * Round-robin arbitration of two byte sources (A, B) onto the PPU input
//     strobe/ack port (IDLE -> SEND -> WAIT handshake FSM).
//   * Frame timing: PPU sync pulse after reset release or a resync request,
//     horizontal/vertical position counters, frame_start pulse at wrap, and
//     frame-aligned application of a pending PPU mode.
//   * Drains PPU pixels into a small FIFO that the VGA output stage pops.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   resync                request a frame restart (sync pulse next cycle)
//   req_a/b, data_a/b     source byte requests and data
//   gnt_a/b               one-cycle "byte taken" pulse (same cycle as request)
//   mode_wr, mode_req     write the pending PPU mode
//   ppu_sync, ppu_mode    PPU counter reset pulse, active PPU mode
//   ppu_data_i, ppu_stb_i byte and strobe towards the PPU, ppu_ack_i its ack
//   ppu_data_o, ppu_stb_o pixel from the PPU, ppu_ack_o accept pulse
//   pix_data, pix_valid   FIFO head towards the VGA stage, pix_ready pops
//   frame_start           pulse in the cycle the position wraps to a new frame
//   underrun_cnt          pops attempted on an empty FIFO (statistics build)
//
// Configuration macro:
//   PPU_SCHED_STATS_EN    when defined, builds the saturating underrun counter;
//                         otherwise underrun_cnt is tied to zero.

module ppu_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE       = 799,
    parameter int SCREEN     = 524
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resync,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [7:0]  data_a,
    input  logic [7:0]  data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    input  logic        mode_wr,
    input  logic [2:0]  mode_req,
    output logic        ppu_sync,
    output logic [2:0]  ppu_mode,
    output logic [7:0]  ppu_data_i,
    output logic        ppu_stb_i,
    input  logic        ppu_ack_i,
    input  logic [7:0]  ppu_data_o,
    input  logic        ppu_stb_o,
    output logic        ppu_ack_o,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_start,
    output logic [15:0] underrun_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int XW = $clog2(LINE + 1);
    localparam int YW = $clog2(SCREEN + 1);
    localparam logic [XW-1:0] X_LAST = XW'(LINE);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // ------------------------------------------------------------------
    // Input arbiter
    // ------------------------------------------------------------------
    arb_state_t  state_q;
    logic        last_b_q;       // 1 when B was granted last (A then has priority)
    logic [7:0]  ppu_data_i_q;
    logic        ppu_stb_i_q;
    logic        pick_a_s;
    logic        pick_b_s;

    // Round-robin pick; the grant is a same-cycle pulse so that the next
    // grant can follow the PPU ack without an extra idle cycle.
    always_comb begin
        pick_a_s = 1'b0;
        pick_b_s = 1'b0;
        if (rst && (state_q == ST_IDLE)) begin
            if (req_a && (!req_b || last_b_q)) begin
                pick_a_s = 1'b1;
            end else if (req_b) begin
                pick_b_s = 1'b1;
            end else begin
                pick_a_s = 1'b0;
                pick_b_s = 1'b0;
            end
        end else begin
            pick_a_s = 1'b0;
            pick_b_s = 1'b0;
        end
    end

    // Arbiter FSM with registered strobe and data towards the PPU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_b_q     <= 1'b1;
            ppu_data_i_q <= 8'd0;
            ppu_stb_i_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_a_s || pick_b_s) begin
                        ppu_data_i_q <= pick_a_s ? data_a : data_b;
                        last_b_q     <= pick_b_s;
                        ppu_stb_i_q  <= 1'b1;   // strobe is high during SEND
                        state_q      <= ST_SEND;
                    end else begin
                        ppu_stb_i_q  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    ppu_stb_i_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    ppu_stb_i_q <= 1'b0;
                    if (ppu_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ppu_stb_i_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_a      = pick_a_s;
    assign gnt_b      = pick_b_s;
    assign ppu_data_i = ppu_data_i_q;
    assign ppu_stb_i  = ppu_stb_i_q;

    // ------------------------------------------------------------------
    // Frame timing and mode
    // ------------------------------------------------------------------
    logic          arm_q;        // set while in reset: forces the first sync pulse
    logic          sync_q, sync_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic          fs_q, fs_d;
    logic [2:0]    mode_q, mode_d;
    logic [2:0]    pend_q, pend_d;
    logic          pflag_q, pflag_d;
    logic          apply_s;

    // Next-state for sync, position, frame_start and mode registers.
    always_comb begin
        sync_d = arm_q | resync;
        if (sync_q) begin
            sx_d = {XW{1'b0}};
            sy_d = {YW{1'b0}};
        end else if (sx_q == X_LAST) begin
            sx_d = {XW{1'b0}};
            if (sy_q == Y_LAST) begin
                sy_d = {YW{1'b0}};
            end else begin
                sy_d = sy_q + YW'(1'b1);
            end
        end else begin
            sx_d = sx_q + XW'(1'b1);
            sy_d = sy_q;
        end
        // frame_start is registered: it is high exactly while the position is the last pixel
        fs_d = (sx_d == X_LAST) && (sy_d == Y_LAST);

        // The pending value (start-of-cycle) is applied at the end of a frame_start/sync cycle;
        // a write in that same cycle becomes the new pending value.
        apply_s = (fs_q | sync_q) & pflag_q;
        mode_d  = apply_s ? pend_q : mode_q;
        if (mode_wr) begin
            pend_d  = mode_req;
            pflag_d = 1'b1;
        end else if (apply_s) begin
            pend_d  = pend_q;
            pflag_d = 1'b0;
        end else begin
            pend_d  = pend_q;
            pflag_d = pflag_q;
        end
    end

    // Timing and mode registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            arm_q   <= 1'b1;
            sync_q  <= 1'b0;
            sx_q    <= {XW{1'b0}};
            sy_q    <= {YW{1'b0}};
            fs_q    <= 1'b0;
            mode_q  <= 3'd0;
            pend_q  <= 3'd0;
            pflag_q <= 1'b0;
        end else begin
            arm_q   <= 1'b0;
            sync_q  <= sync_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            fs_q    <= fs_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
        end
    end

    assign ppu_sync    = sync_q;
    assign frame_start = fs_q;
    assign ppu_mode    = mode_q;

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ack_o_q;
    logic          push_s;
    logic          pop_s;

    // Push/pop decisions; the full check uses the start-of-cycle level, so a
    // pop never makes room for a push in the same cycle. A push is never taken
    // while the previous accept is still being signalled, so one held pixel is
    // written exactly once.
    always_comb begin
        push_s   = ppu_stb_o & ~ack_o_q & (level_q < LVL_FULL);
        pop_s    = (level_q != {LW{1'b0}}) & pix_ready;
        level_d  = level_q + LW'(push_s) - LW'(pop_s);
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
    end

    // FIFO control registers and accept pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            ack_o_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_o_q  <= push_s;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= ppu_data_o;
        end
    end

    assign ppu_ack_o = ack_o_q;
    assign pix_valid = (level_q != {LW{1'b0}});
    assign pix_data  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef PPU_SCHED_STATS_EN
    logic [15:0] under_q, under_d;

    // Saturating count of pop attempts on an empty FIFO; cleared by sync.
    always_comb begin
        if (sync_q) begin
            under_d = 16'd0;
        end else if (pix_ready && (level_q == {LW{1'b0}}) && (under_q != 16'hFFFF)) begin
            under_d = under_q + 16'd1;
        end else begin
            under_d = under_q;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            under_q <= 16'd0;
        end else begin
            under_q <= under_d;
        end
    end

    assign underrun_cnt = under_q;
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ppu_sched.sv
module tb_ppu_sched;

    localparam int D  = 4;
    localparam int LN = 15;
    localparam int SC = 9;
    localparam int P  = (LN + 1) * (SC + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, resync, req_a, req_b, mode_wr, ppu_ack_i, ppu_stb_o, pix_ready;
    logic [7:0]  data_a, data_b, ppu_data_o;
    logic [2:0]  mode_req;
    logic        gnt_a, gnt_b, ppu_sync, ppu_stb_i, ppu_ack_o, pix_valid, frame_start;
    logic [2:0]  ppu_mode;
    logic [7:0]  ppu_data_i, pix_data;
    logic [15:0] underrun_cnt;

    ppu_sched #(.FIFO_DEPTH(D), .LINE(LN), .SCREEN(SC)) dut (
        .clk(clk), .rst(rst), .resync(resync),
        .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .mode_wr(mode_wr), .mode_req(mode_req),
        .ppu_sync(ppu_sync), .ppu_mode(ppu_mode),
        .ppu_data_i(ppu_data_i), .ppu_stb_i(ppu_stb_i), .ppu_ack_i(ppu_ack_i),
        .ppu_data_o(ppu_data_o), .ppu_stb_o(ppu_stb_o), .ppu_ack_o(ppu_ack_o),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_start(frame_start), .underrun_cnt(underrun_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // stimulus requested by the test sequences, applied at the next negedge
    bit       s_rst = 0, s_resync = 0, s_req_a = 0, s_req_b = 0, s_mode_wr = 0, s_ready = 0;
    bit [7:0] s_da = 8'd0, s_db = 8'd0;
    bit [2:0] s_mode_req = 3'd0;
    bit       ppu_stream = 0, ppu_rand = 0, ack_rand = 0, ack_block = 0;

    // PPU responder state
    bit       ppu_has = 0;
    bit [7:0] ppu_pix = 8'd0, pix_ctr = 8'd0;
    bit       ack_prev = 0;

    // reference model
    bit         m_known = 0;
    int         cyc = 0;
    bit         m_open = 0;
    int         m_gnt_t = 0;
    bit         m_last_b = 1;
    bit [7:0]   m_byte = 8'd0;
    bit         m_sync = 0, m_arm = 0;
    int         m_pos = 0;
    bit [2:0]   m_mode = 3'd0, m_pend = 3'd0;
    bit         m_pflag = 0;
    bit [7:0]   m_q[$];
    bit         m_ack = 0;
    int         m_under = 0;

    // values observed in the most recent step
    logic       o_gnt_a, o_gnt_b, o_stb_i, o_sync, o_fs, o_ack_o, o_valid;
    logic [7:0] o_data_i, o_pdata;
    logic [2:0] o_mode;
    logic [15:0] o_under;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check against the model, advance the model.
    task automatic step();
        bit e_ga, e_gb, e_stb, e_fs, push, pop, apply;
        int e_under;
        @(negedge clk);
        if (!s_rst || ack_prev) ppu_has = 1'b0;
        if (!ppu_has && ppu_stream && (!ppu_rand || $urandom_range(0, 2) != 0)) begin
            ppu_has = 1'b1;
            ppu_pix = pix_ctr;
            pix_ctr = pix_ctr + 8'd1;
        end
        rst = s_rst; resync = s_resync; req_a = s_req_a; req_b = s_req_b;
        data_a = s_da; data_b = s_db; mode_wr = s_mode_wr; mode_req = s_mode_req;
        pix_ready = s_ready; ppu_stb_o = ppu_has; ppu_data_o = ppu_pix;
        ppu_ack_i = m_open && (cyc >= m_gnt_t + 2) && !ack_block &&
                    (!ack_rand || $urandom_range(0, 1) == 1);
        #1;
        o_gnt_a = gnt_a; o_gnt_b = gnt_b; o_stb_i = ppu_stb_i; o_data_i = ppu_data_i;
        o_sync = ppu_sync; o_fs = frame_start; o_mode = ppu_mode; o_ack_o = ppu_ack_o;
        o_valid = pix_valid; o_pdata = pix_data; o_under = underrun_cnt;

        e_ga  = rst && !m_open && req_a && (!req_b || m_last_b);
        e_gb  = rst && !m_open && req_b && !e_ga;
        e_stb = m_open && (cyc == m_gnt_t + 1);
        e_fs  = (m_pos == P - 1);
`ifdef PPU_SCHED_STATS_EN
        e_under = m_under;
`else
        e_under = 0;
`endif
        if (m_known) begin
            chk("gnt_a", o_gnt_a, e_ga);
            chk("gnt_b", o_gnt_b, e_gb);
            chk("ppu_stb_i", o_stb_i, e_stb);
            if (e_stb) chk("ppu_data_i", o_data_i, m_byte);
            chk("ppu_sync", o_sync, m_sync);
            chk("frame_start", o_fs, e_fs);
            chk("ppu_mode", o_mode, m_mode);
            chk("ppu_ack_o", o_ack_o, m_ack);
            chk("pix_valid", o_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("pix_data", o_pdata, m_q[0]);
            chk("underrun_cnt", o_under, e_under);
        end

        ack_prev = m_ack;
        if (!rst) begin
            m_known = 1; m_open = 0; m_last_b = 1; m_byte = 8'd0;
            m_sync = 0; m_arm = 1; m_pos = 0; m_mode = 3'd0; m_pend = 3'd0;
            m_pflag = 0; m_q.delete(); m_ack = 0; m_under = 0;
        end else begin
            push = ppu_stb_o && !m_ack && (m_q.size() < D);
            pop  = (m_q.size() > 0) && pix_ready;
            if (m_sync) m_under = 0;
            else if (pix_ready && m_q.size() == 0 && m_under < 65535) m_under++;
            apply = (e_fs || m_sync) && m_pflag;
            if (apply) m_mode = m_pend;
            if (mode_wr) begin m_pend = mode_req; m_pflag = 1; end
            else if (apply) m_pflag = 0;
            m_pos  = m_sync ? 0 : (m_pos + 1) % P;
            m_sync = m_arm || resync;
            m_arm  = 0;
            if (e_ga || e_gb) begin
                m_open = 1; m_gnt_t = cyc; m_last_b = e_gb;
                m_byte = e_ga ? data_a : data_b;
            end else if (m_open && cyc >= m_gnt_t + 2 && ppu_ack_i) begin
                m_open = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(ppu_data_o);
            m_ack = push;
        end
        cyc++;
    endtask

    typedef struct {
        bit ra; bit rb; bit [7:0] da; bit [7:0] db;
        bit ega; bit egb; bit [7:0] eb;
    } vec_t;

    vec_t vecs[8];
    int   k, got, acks, popped, last_t, nstb;
    bit   found, prev_stb;
    bit [7:0] prev_d;

    initial begin
        rst = 0; resync = 0; req_a = 0; req_b = 0; data_a = 0; data_b = 0;
        mode_wr = 0; mode_req = 0; ppu_ack_i = 0; ppu_stb_o = 0; ppu_data_o = 0; pix_ready = 0;

        // round-robin vectors, applied in order from reset (A has priority first)
        vecs[0] = '{1, 1, 8'hA0, 8'hB0, 1, 0, 8'hA0};
        vecs[1] = '{1, 1, 8'hA1, 8'hB1, 0, 1, 8'hB1};
        vecs[2] = '{1, 0, 8'hA2, 8'hB2, 1, 0, 8'hA2};
        vecs[3] = '{1, 1, 8'hA3, 8'hB3, 0, 1, 8'hB3};
        vecs[4] = '{0, 1, 8'hA4, 8'hB4, 0, 1, 8'hB4};
        vecs[5] = '{1, 1, 8'hA5, 8'hB5, 1, 0, 8'hA5};
        vecs[6] = '{0, 1, 8'hA6, 8'hB6, 0, 1, 8'hB6};
        vecs[7] = '{1, 1, 8'hA7, 8'hB7, 1, 0, 8'hA7};

        // reset, release, sync pulse
        s_rst = 0;
        repeat (3) step();
        s_rst = 1;
        step();
        chk("rst_sync", o_sync, 0);
        chk("rst_mode", o_mode, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_stb_i", o_stb_i, 0);
        chk("rst_data_i", o_data_i, 0);
        chk("rst_ack_o", o_ack_o, 0);
        chk("rst_fs", o_fs, 0);
        step();
        chk("sync_after_release", o_sync, 1);

        // frame 1: mode 3 written mid-frame, applied after frame_start
        found = 0; k = 0;
        for (int j = 1; j <= 400 && !found; j++) begin
            s_mode_wr = (j == 10); s_mode_req = 3'd3;
            step();
            if (j == 1) chk("sync_one_cycle", o_sync, 0);
            if (o_fs) begin found = 1; k = j; end
            else if (j > 10) chk("mode_held_mid_frame", o_mode, 0);
        end
        s_mode_wr = 0;
        chk("first_frame_start_delay", k, P);
        chk("mode_in_fs_cycle", o_mode, 0);
        step();
        chk("mode_after_frame", o_mode, 3);

        // frame 2: write 2 then 5, the later write wins
        found = 0; k = 0;
        for (int j = 1; j <= 400 && !found; j++) begin
            s_mode_wr = (j == 20) || (j == 40);
            s_mode_req = (j == 20) ? 3'd2 : 3'd5;
            step();
            if (o_fs) begin found = 1; k = j + 1; end
            else chk("mode_held_frame2", o_mode, 3);
        end
        s_mode_wr = 0;
        chk("frame_period", k, P);
        step();
        chk("mode_overwritten", o_mode, 5);

        // table-driven arbitration vectors
        for (int i = 0; i < 8; i++) begin
            s_req_a = vecs[i].ra; s_req_b = vecs[i].rb; s_da = vecs[i].da; s_db = vecs[i].db;
            step();
            chk("vec_gnt_a", o_gnt_a, vecs[i].ega);
            chk("vec_gnt_b", o_gnt_b, vecs[i].egb);
            s_req_a = 0; s_req_b = 0;
            got = 0;
            for (int w = 0; w < 8; w++) begin
                step();
                if (o_stb_i) begin got++; chk("vec_byte", o_data_i, vecs[i].eb); end
            end
            chk("vec_stb_count", got, 1);
        end

        // both sources held: alternating bytes, 3-cycle spacing
        s_req_a = 1; s_req_b = 1; s_da = 8'h11; s_db = 8'h22;
        prev_stb = 0; nstb = 0; last_t = 0; prev_d = 8'h00;
        for (int w = 0; w < 14; w++) begin
            step();
            chk("no_back_to_back_stb", prev_stb && o_stb_i, 0);
            if (o_stb_i) begin
                if (nstb == 0) chk("alt_first", o_data_i, 8'h22);
                else begin
                    chk("alt_spacing", w - last_t, 3);
                    chk("alt_byte", o_data_i, (prev_d == 8'h11) ? 8'h22 : 8'h11);
                end
                nstb++; last_t = w; prev_d = o_data_i;
            end
            prev_stb = o_stb_i;
        end
        chk("alt_count", nstb >= 4, 1);
        s_req_a = 0; s_req_b = 0;
        repeat (4) step();

        // FIFO fill without consumer, then drain in order
        s_ready = 0; ppu_stream = 1; ppu_rand = 0; acks = 0;
        for (int w = 0; w < 20; w++) begin
            step();
            if (o_ack_o) acks++;
        end
        chk("fill_pushes", acks, D);
        chk("ack_held_low", o_ack_o, 0);
        chk("full_valid", o_valid, 1);
        ppu_stream = 0; s_ready = 1; popped = 0;
        for (int w = 0; w < 30; w++) begin
            step();
            if (o_valid) begin chk("pop_order", o_pdata, popped); popped++; end
        end
        chk("pop_count", popped, D + 1);

        // reset while in WAIT with two FIFO entries
        s_ready = 0; ppu_stream = 1;
        for (int w = 0; w < 20 && m_q.size() < 2; w++) step();
        ppu_stream = 0;
        repeat (2) step();
        ack_block = 1; s_req_a = 1; s_da = 8'h5A;
        step();
        s_req_a = 0;
        repeat (3) step();
        chk("pre_rst_valid", o_valid, 1);
        s_rst = 0;
        step();
        s_rst = 1;
        step();
        chk("midrst_valid", o_valid, 0);
        chk("midrst_stb_i", o_stb_i, 0);
        chk("midrst_ack_o", o_ack_o, 0);
        chk("midrst_mode", o_mode, 0);
        chk("midrst_sync", o_sync, 0);
        ack_block = 0; s_req_a = 1; s_da = 8'h3C;
        step();
        chk("midrst_sync_after", o_sync, 1);
        chk("midrst_idle_grant", o_gnt_a, 1);
        s_req_a = 0;
        repeat (6) step();

        // underrun counter: 10 pops on an empty FIFO
        s_rst = 0;
        step();
        s_rst = 1;
        step();
        step();
        s_ready = 1;
        repeat (10) step();
        s_ready = 0;
        step();
`ifdef PPU_SCHED_STATS_EN
        chk("underrun_10", o_under, 10);
`else
        chk("underrun_tied", o_under, 0);
`endif

        // randomized traffic against the model
        ppu_stream = 1; ppu_rand = 1; ack_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            s_rst      = ($urandom_range(0, 499) != 0);
            s_resync   = ($urandom_range(0, 79) == 0);
            s_req_a    = $urandom_range(0, 1);
            s_req_b    = $urandom_range(0, 1);
            s_da       = 8'($urandom);
            s_db       = 8'($urandom);
            s_mode_wr  = ($urandom_range(0, 29) == 0);
            s_mode_req = 3'($urandom);
            s_ready    = $urandom_range(0, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
